// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// instruction_fetch_unit_pkg: types and constants shared by the fetch/decode front end.
package instruction_fetch_unit_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  // addi x0, x0, 0 -- inserted by decode as a bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// fetch_fifo: synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output fetch_entry_t               head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// instruction_fetch_unit: credit-limited PC sequencer feeding a small instruction buffer,
// with redirect flush and in-flight response discard.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding_after_rsp;
  logic          fifo_empty;
  logic          credit;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // In-flight requests reserve a buffer slot, so the FIFO can never overflow.
  assign credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);

  assign imem_req_valid = !reset && !redirect_valid && credit;
  assign imem_req_addr  = word_align(fetch_pc);
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire              = imem_rsp_valid && (outstanding != '0);
  assign outstanding_after_rsp = outstanding - CW'(rsp_fire);

  assign push       = rsp_fire && !redirect_valid && (discard_cnt == '0);
  assign pop        = id_valid && id_ready;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= word_align(redirect_pc);
      rsp_pc      <= word_align(redirect_pc);
      outstanding <= outstanding_after_rsp;
      // Earlier discards are a subset of outstanding, so after a redirect every
      // response still in flight is wrong-path; this also keeps chained redirects exact.
      discard_cnt <= outstanding_after_rsp;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire) begin
        if (discard_cnt != '0) begin
          discard_cnt <= discard_cnt - 1'b1;
        end else begin
          rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign id_valid       = !fifo_empty;
  assign id_pc          = head.pc;
  assign id_instruction = head.instr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit: random memory/decode/redirect traffic against a request-tagging reference model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instruction(id_instruction),
    .id_pc         (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          wrong;
  } req_t;

  req_t         pending[$];
  fetch_entry_t expq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           lat_now = 1;
  int           rmode = 0;     // 0: ready=1, 1: toggle, 2: random, 3: ready=0
  int           idmode = 1;    // 0: id_ready=0, 1: id_ready=1, 2: random
  int           latcfg = 1;    // 0: random 1..3, else fixed latency
  bit           popped_now = 0;
  bit           prev_rst = 1;
  logic [31:0]  fetch_m = RESET_PC;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the decode-side output against the scoreboard head.
  always @(posedge clk) begin
    #3;
    popped_now = 0;
    if (reset) begin
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("rst_id_pc", {32'd0, id_pc}, 64'd0);
        chk("rst_id_instr", {32'd0, id_instruction}, 64'd0);
      end
      prev_rst = 0;
      chk("id_valid", {63'd0, id_valid}, {63'd0, expq.size() != 0});
      if (id_valid && expq.size() != 0) begin
        chk("id_entry", {id_pc, id_instruction}, {expq[0].pc, expq[0].instr});
        if (id_ready) begin
          void'(expq.pop_front());
          popped_now = 1;
        end
      end
    end
  end

  // Reference model: tags every accepted request; a redirect turns all in-flight tags wrong-path.
  always @(negedge clk) begin
    int   psz;
    int   fsz;
    req_t p;
    req_t t;
    psz = pending.size();
    fsz = expq.size() + int'(popped_now);
    if (reset) begin
      chk("req_valid_in_reset", {63'd0, imem_req_valid}, 64'd0);
      pending.delete();
      expq.delete();
      fetch_m = RESET_PC;
    end else begin
      chk("req_valid_credit", {63'd0, imem_req_valid},
          {63'd0, !redirect_valid && (psz + fsz < DEPTH)});
      if (imem_rsp_valid && pending.size() != 0) begin
        p = pending.pop_front();
        if (!p.wrong && !redirect_valid) expq.push_back('{pc: p.addr, instr: memword(p.addr)});
      end
      if (redirect_valid) begin
        expq.delete();
        for (int i = 0; i < pending.size(); i++) begin
          t = pending[i];
          t.wrong = 1;
          pending[i] = t;
        end
        fetch_m = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", {32'd0, imem_req_addr}, {32'd0, fetch_m});
        pending.push_back('{addr: fetch_m, due: cyc + lat_now, wrong: 1'b0});
        fetch_m = fetch_m + 32'd4;
      end
    end
  end

  // Drives all DUT inputs for one cycle, including the in-order memory responder.
  task automatic step(input bit rd = 0, input logic [31:0] rpc = 32'd0, input bit rst = 0);
    @(posedge clk);
    #1;
    reset          = rst;
    redirect_valid = rd;
    redirect_pc    = rpc;
    case (rmode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = (cyc % 2) == 0;
      2:       imem_req_ready = $urandom_range(0, 1) == 1;
      default: imem_req_ready = 1'b0;
    endcase
    case (idmode)
      0:       id_ready = 1'b0;
      1:       id_ready = 1'b1;
      default: id_ready = $urandom_range(0, 3) != 0;
    endcase
    lat_now = (latcfg == 0) ? int'($urandom_range(1, 3)) : latcfg;
    if (!rst && pending.size() != 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(pending[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  initial begin
    int n;
    step(0, 0, 1);
    step(0, 0, 1);
    // Streaming with a zero-wait memory.
    rmode = 0; idmode = 1; latcfg = 1;
    repeat (20) step();
    // Decode stall then release.
    idmode = 0;
    repeat (10) step();
    idmode = 1;
    repeat (10) step();
    // Toggling ready with 2-cycle memory.
    rmode = 1; latcfg = 2;
    repeat (30) step();
    // Redirect with requests in flight and entries buffered.
    rmode = 0; idmode = 0;
    repeat (3) step();
    step(1, 32'h0000_0100);
    idmode = 1;
    repeat (12) step();
    // Unaligned target, redirect while responses and pops are in flight.
    latcfg = 1;
    repeat (5) step();
    step(1, 32'h0000_0203);
    repeat (10) step();
    // Back-to-back redirects with a slow memory.
    latcfg = 3;
    repeat (4) step();
    step(1, 32'h0000_0400);
    step(1, 32'h0000_0800);
    repeat (15) step();
    // Address wrap at the top of memory.
    latcfg = 1;
    step(1, 32'hFFFF_FFF8);
    repeat (10) step();
    // Reset mid-stream with entries buffered.
    idmode = 0;
    repeat (5) step();
    step(0, 0, 1);
    idmode = 1;
    repeat (10) step();
    // Random traffic with occasional redirects and resets.
    rmode = 2; idmode = 2; latcfg = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 20) == 0, $urandom, ($urandom % 150) == 0);
    end
    // Drain: stop new requests and let everything flow out.
    rmode = 3; idmode = 1;
    n = 0;
    while ((pending.size() != 0 || expq.size() != 0) && n < 60) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("drain_pending", 64'(pending.size()), 64'd0);
    chk("drain_expected", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
